multicycle_control: RTL and testbench

- Multicycle sequencer for the LEGv8 datapath: one shared ALU, separate instruction/data memory ports, each with a ready handshake.
- Latches each fetched opcode and steps through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same datapath control set as the single-cycle decoder, plus PC/IR write enables, a retire counter and a memory-timeout fault.

---
 rtl/multicycle_control_if.sv | 48 ++++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle LEGv8 sequencer and its datapath/memories.
//   opcode      : instruction[31:21]; valid while imem_ready=1
//   imem_ready  : instruction memory data valid
//   dmem_ready  : data memory access complete
//   zero        : ALU zero flag (sampled in EXEC for CBZ)
//   imem_req, irwrite, pcwrite, pcsrc : fetch / PC control
//   reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop :
//               datapath controls
//   illegal, fault : one-cycle exception pulses
//   retired     : retired-instruction counter
// The master modport is the sequencer; the slave modport is the datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             zero;
    logic             imem_req;
    logic             irwrite;
    logic             pcwrite;
    logic             pcsrc;
    logic             reg2loc;
    logic             alusrc;
    logic             mem2reg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic [3:0]       aluop;
    logic [2:0]       signop;
    logic             illegal;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, imem_ready, dmem_ready, zero,
        output imem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg,
               regwrite, memread, memwrite, aluop, signop, illegal, fault,
               retired
    );

    modport slave (
        output opcode, imem_ready, dmem_ready, zero,
        input  imem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg,
               regwrite, memread, memwrite, aluop, signop, illegal, fault,
               retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Latches the fetched opcode, drives the datapath control set, counts
// retired instructions and aborts memory waits after TIMEOUT cycles.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : multicycle_control_if master modport (see interface header)
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam int WCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WCNT_W-1:0] FETCH_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] MEM_LIMIT  = WCNT_W'(TIMEOUT);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ILL, C_LDUR, C_STUR, C_ALU, C_B, C_CBZ} cls_t;

    state_t             state_reg, state_next;
    logic [10:0]        op_reg, op_next;
    logic [WCNT_W-1:0]  wcnt_reg, wcnt_next;
    logic [CNT_W-1:0]   retired_reg, retired_next;

    // Static decode of the latched opcode.
    cls_t       cls;
    logic [3:0] aluop_dec;
    logic [2:0] signop_dec;
    logic       reg2loc_dec, alusrc_dec, mem2reg_dec;

    always_comb begin
        cls         = C_ILL;
        aluop_dec   = 4'b0000;
        signop_dec  = 3'b000;
        reg2loc_dec = 1'b0;
        alusrc_dec  = 1'b0;
        mem2reg_dec = 1'b0;
        casez (op_reg)
            11'b11111000010: begin cls = C_LDUR; aluop_dec = 4'b0010; signop_dec = 3'b001;
                                   alusrc_dec = 1'b1; mem2reg_dec = 1'b1; end
            11'b11111000000: begin cls = C_STUR; aluop_dec = 4'b0010; signop_dec = 3'b001;
                                   alusrc_dec = 1'b1; reg2loc_dec = 1'b1; end
            11'b10001011000: begin cls = C_ALU; aluop_dec = 4'b0010; end
            11'b11001011000: begin cls = C_ALU; aluop_dec = 4'b0110; end
            11'b10001010000: begin cls = C_ALU; aluop_dec = 4'b0000; end
            11'b10101010000: begin cls = C_ALU; aluop_dec = 4'b0001; end
            11'b1001000100?: begin cls = C_ALU; aluop_dec = 4'b0010; alusrc_dec = 1'b1; end
            11'b1101000100?: begin cls = C_ALU; aluop_dec = 4'b0110; alusrc_dec = 1'b1; end
            // MOVZ: hw field selects the 16-bit lane of the shifted immediate
            11'b110100101??: begin cls = C_ALU; aluop_dec = 4'b0111; alusrc_dec = 1'b1;
                                   signop_dec = {1'b1, op_reg[1:0]}; end
            11'b000101?????: begin cls = C_B; aluop_dec = 4'b0111; signop_dec = 3'b011; end
            11'b10110100???: begin cls = C_CBZ; aluop_dec = 4'b0111; signop_dec = 3'b010;
                                   reg2loc_dec = 1'b1; end
            default:         cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            wcnt_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            wcnt_reg    <= wcnt_next;
            retired_reg <= retired_next;
        end
    end

    logic imem_req_c, irwrite_c, pcwrite_c, pcsrc_c, regwrite_c;
    logic memread_c, memwrite_c, illegal_c, fault_c;

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        wcnt_next    = '0;          // only the waiting states keep counting
        retired_next = retired_reg;
        imem_req_c   = 1'b0;
        irwrite_c    = 1'b0;
        pcwrite_c    = 1'b0;
        pcsrc_c      = 1'b0;
        regwrite_c   = 1'b0;
        memread_c    = 1'b0;
        memwrite_c   = 1'b0;
        illegal_c    = 1'b0;
        fault_c      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    irwrite_c  = 1'b1;
                    op_next    = bus.opcode;
                    state_next = S_DECODE;
                end else if (wcnt_reg == FETCH_LAST) begin
                    // abort this fetch attempt and keep requesting
                    fault_c = 1'b1;
                end else begin
                    wcnt_next = wcnt_reg + 1'b1;
                end
            end
            S_DECODE: begin
                if (cls == C_ILL) begin
                    // retire as a no-op so the PC moves past the bad word
                    illegal_c    = 1'b1;
                    pcwrite_c    = 1'b1;
                    retired_next = retired_reg + 1'b1;
                    state_next   = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_LDUR, C_STUR: state_next = S_MEM;
                    C_B, C_CBZ: begin
                        pcwrite_c    = 1'b1;
                        pcsrc_c      = (cls == C_B) ? 1'b1 : bus.zero;
                        retired_next = retired_reg + 1'b1;
                        state_next   = S_FETCH;
                    end
                    default: state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (wcnt_reg == MEM_LIMIT) begin
                    // access skipped: strobes drop, instruction still retires
                    fault_c      = 1'b1;
                    pcwrite_c    = 1'b1;
                    retired_next = retired_reg + 1'b1;
                    state_next   = S_FETCH;
                end else begin
                    memread_c  = (cls == C_LDUR);
                    memwrite_c = (cls == C_STUR);
                    if (bus.dmem_ready) begin
                        if (cls == C_LDUR) begin
                            state_next = S_WB;
                        end else begin
                            pcwrite_c    = 1'b1;
                            retired_next = retired_reg + 1'b1;
                            state_next   = S_FETCH;
                        end
                    end else begin
                        wcnt_next = wcnt_reg + 1'b1;
                    end
                end
            end
            S_WB: begin
                regwrite_c   = 1'b1;
                pcwrite_c    = 1'b1;
                retired_next = retired_reg + 1'b1;
                state_next   = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Every control is forced low while reset is held, independent of state.
    assign bus.imem_req = imem_req_c  & ~rst;
    assign bus.irwrite  = irwrite_c   & ~rst;
    assign bus.pcwrite  = pcwrite_c   & ~rst;
    assign bus.pcsrc    = pcsrc_c     & ~rst;
    assign bus.regwrite = regwrite_c  & ~rst;
    assign bus.memread  = memread_c   & ~rst;
    assign bus.memwrite = memwrite_c  & ~rst;
    assign bus.illegal  = illegal_c   & ~rst;
    assign bus.fault    = fault_c     & ~rst;
    assign bus.reg2loc  = reg2loc_dec & ~rst;
    assign bus.alusrc   = alusrc_dec  & ~rst;
    assign bus.mem2reg  = mem2reg_dec & ~rst;
    assign bus.aluop    = aluop_dec   & {4{~rst}};
    assign bus.signop   = signop_dec  & {3{~rst}};
    assign bus.retired  = retired_reg;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // strobe vector layout: {imem_req, irwrite, pcwrite, pcsrc, regwrite,
    //                        memread, memwrite, illegal, fault}
    localparam logic [8:0] REQ = 9'h100, IRW = 9'h080, PCW = 9'h040, PCS = 9'h020,
                           RW  = 9'h010, MR  = 9'h008, MW  = 9'h004, ILL = 9'h002,
                           FLT = 9'h001;
    localparam int K_ILL = 0, K_LD = 1, K_ST = 2, K_ALU = 3, K_B = 4, K_CBZ = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          exp_ret     = 0;
    logic [9:0]  prev_dec    = '0;   // {reg2loc, alusrc, mem2reg, aluop, signop}
    string       tag         = "";

    typedef struct {
        logic [10:0] op;
        int          fw;
        int          mw;
        logic        z;
        logic [9:0]  dec;
    } vec_t;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] junk();
        return 11'($urandom);
    endfunction

    // Reference decode written from the opcode class table.
    task automatic ref_model(input logic [10:0] op, output int cls, output logic [9:0] dec);
        cls = K_ILL;
        dec = '0;
        casez (op)
            11'h7C2:         begin cls = K_LD;  dec = {3'b011, 4'b0010, 3'b001}; end
            11'h7C0:         begin cls = K_ST;  dec = {3'b110, 4'b0010, 3'b001}; end
            11'h458:         begin cls = K_ALU; dec = {3'b000, 4'b0010, 3'b000}; end
            11'h658:         begin cls = K_ALU; dec = {3'b000, 4'b0110, 3'b000}; end
            11'h450:         begin cls = K_ALU; dec = {3'b000, 4'b0000, 3'b000}; end
            11'h550:         begin cls = K_ALU; dec = {3'b000, 4'b0001, 3'b000}; end
            11'b1001000100?: begin cls = K_ALU; dec = {3'b010, 4'b0010, 3'b000}; end
            11'b1101000100?: begin cls = K_ALU; dec = {3'b010, 4'b0110, 3'b000}; end
            11'b110100101??: begin cls = K_ALU; dec = {3'b010, 4'b0111, 1'b1, op[1:0]}; end
            11'b000101?????: begin cls = K_B;   dec = {3'b000, 4'b0111, 3'b011}; end
            11'b10110100???: begin cls = K_CBZ; dec = {3'b100, 4'b0111, 3'b010}; end
            default:         begin cls = K_ILL; dec = '0; end
        endcase
    endtask

    function automatic logic [8:0] got_strb();
        return {bus.imem_req, bus.irwrite, bus.pcwrite, bus.pcsrc, bus.regwrite,
                bus.memread, bus.memwrite, bus.illegal, bus.fault};
    endfunction

    function automatic logic [9:0] got_dec();
        return {bus.reg2loc, bus.alusrc, bus.mem2reg, bus.aluop, bus.signop};
    endfunction

    // One clock cycle: entered just after a falling edge, drive inputs,
    // compare the combinational outputs, then move to the next falling edge.
    task automatic step(input logic [10:0] op, input logic ir, input logic dr,
                        input logic z, input logic [8:0] e_strb, input logic [9:0] e_dec);
        logic [CNT_W-1:0] e_ret;
        bus.opcode     = op;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.zero       = z;
        #1;
        e_ret = CNT_W'(exp_ret);
        vectors++;
        if (got_strb() !== e_strb || got_dec() !== e_dec || bus.retired !== e_ret) begin
            miscompares++;
            $display("FAIL %s: strobes got %b want %b, dec got %b want %b, retired got %0d want %0d",
                     tag, got_strb(), e_strb, got_dec(), e_dec, bus.retired, e_ret);
        end
        if (e_strb[6]) exp_ret++;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Build the expected cycle trace of one instruction from the class rules
    // and check the DUT against it cycle by cycle.
    task automatic run_instr(input logic [10:0] op, input logic [9:0] dec, input int fw,
                             input int mw, input logic z, output int ncyc);
        int         c;
        logic [9:0] ref_dec;
        ref_model(op, c, ref_dec);
        ncyc = 0;
        tag  = $sformatf("op%03h", op);
        for (int k = 0; k < fw; k++) begin
            step(junk(), 1'b0, rb(), rb(), (((k + 1) % TMO) == 0) ? (REQ | FLT) : REQ, prev_dec);
            ncyc++;
        end
        step(op, 1'b1, rb(), rb(), REQ | IRW, prev_dec);
        ncyc++;
        prev_dec = dec;
        if (c == K_ILL) begin
            step(junk(), rb(), rb(), rb(), PCW | ILL, dec);
            ncyc++;
        end else begin
            step(junk(), rb(), rb(), rb(), 9'h000, dec);
            ncyc++;
            if (c == K_B) begin
                step(junk(), rb(), rb(), rb(), PCW | PCS, dec);
                ncyc++;
            end else if (c == K_CBZ) begin
                step(junk(), rb(), rb(), z, z ? (PCW | PCS) : PCW, dec);
                ncyc++;
            end else if (c == K_ALU) begin
                step(junk(), rb(), rb(), rb(), 9'h000, dec);
                step(junk(), rb(), rb(), rb(), RW | PCW, dec);
                ncyc += 2;
            end else begin
                step(junk(), rb(), rb(), rb(), 9'h000, dec);
                ncyc++;
                for (int k = 0; k <= TMO; k++) begin
                    if (k == TMO) begin
                        step(junk(), rb(), 1'(k == mw), rb(), FLT | PCW, dec);
                        ncyc++;
                    end else if (k == mw) begin
                        if (c == K_ST) begin
                            step(junk(), rb(), 1'b1, rb(), MW | PCW, dec);
                            ncyc++;
                        end else begin
                            step(junk(), rb(), 1'b1, rb(), MR, dec);
                            step(junk(), rb(), rb(), rb(), RW | PCW, dec);
                            ncyc += 2;
                        end
                        break;
                    end else begin
                        step(junk(), rb(), 1'b0, rb(), (c == K_LD) ? MR : MW, dec);
                        ncyc++;
                    end
                end
            end
        end
    endtask

    task automatic do_instr(input logic [10:0] op, input logic [9:0] dec, input int fw,
                            input int mw, input logic z);
        int n;
        run_instr(op, dec, fw, mw, z, n);
        $display("instr %03h fw=%0d mw=%0d z=%0b cycles=%0d retired=%0d",
                 op, fw, mw, z, n, bus.retired);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[17];
        int          cls;
        logic [9:0]  d;
        logic [10:0] op;
        logic [10:0] pool[10];

        tbl[0]  = '{11'h458, 0, 0,  1'b0, {3'b000, 4'b0010, 3'b000}};
        tbl[1]  = '{11'h7C2, 0, 3,  1'b0, {3'b011, 4'b0010, 3'b001}};
        tbl[2]  = '{11'h5A0, 0, 0,  1'b1, {3'b100, 4'b0111, 3'b010}};
        tbl[3]  = '{11'h5A0, 0, 0,  1'b0, {3'b100, 4'b0111, 3'b010}};
        tbl[4]  = '{11'h7C0, 0, 99, 1'b0, {3'b110, 4'b0010, 3'b001}};
        tbl[5]  = '{11'h7FF, 0, 0,  1'b0, 10'b0};
        tbl[6]  = '{11'h458, 0, 0,  1'b0, {3'b000, 4'b0010, 3'b000}};
        tbl[7]  = '{11'h658, 0, 0,  1'b0, {3'b000, 4'b0110, 3'b000}};
        tbl[8]  = '{11'h450, 0, 0,  1'b0, {3'b000, 4'b0000, 3'b000}};
        tbl[9]  = '{11'h550, 1, 0,  1'b0, {3'b000, 4'b0001, 3'b000}};
        tbl[10] = '{11'h489, 0, 0,  1'b0, {3'b010, 4'b0010, 3'b000}};
        tbl[11] = '{11'h688, 2, 0,  1'b0, {3'b010, 4'b0110, 3'b000}};
        tbl[12] = '{11'h696, 0, 0,  1'b0, {3'b010, 4'b0111, 3'b110}};
        tbl[13] = '{11'h0A5, 0, 0,  1'b1, {3'b000, 4'b0111, 3'b011}};
        tbl[14] = '{11'h458, 5, 0,  1'b0, {3'b000, 4'b0010, 3'b000}};
        tbl[15] = '{11'h7C2, 0, 4,  1'b0, {3'b011, 4'b0010, 3'b001}};
        tbl[16] = '{11'h7C0, 0, 3,  1'b0, {3'b110, 4'b0010, 3'b001}};

        bus.opcode = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.zero = 1'b0;
        #3;
        check("reset_strobes", 32'(got_strb()), 32'h0);
        check("reset_dec",     32'(got_dec()),  32'h0);
        check("reset_retired", 32'(bus.retired), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++)
            do_instr(tbl[i].op, tbl[i].dec, tbl[i].fw, tbl[i].mw, tbl[i].z);

        // Reset while STUR is waiting in MEM.
        tag = "reset_mid";
        ref_model(11'h7C0, cls, d);
        step(11'h7C0, 1'b1, 1'b0, 1'b0, REQ | IRW, prev_dec);
        prev_dec = d;
        step(junk(), 1'b0, 1'b0, 1'b0, 9'h000, d);
        step(junk(), 1'b0, 1'b0, 1'b0, 9'h000, d);
        step(junk(), 1'b0, 1'b0, 1'b0, MW, d);
        bus.dmem_ready = 1'b0;
        #1;
        check("mem_write_before_reset", 32'(bus.memwrite), 32'h1);
        rst = 1'b1;
        #1;
        check("reset_mid_strobes", 32'(got_strb()), 32'h0);
        check("reset_mid_retired", 32'(bus.retired), 32'h0);
        exp_ret  = 0;
        prev_dec = '0;
        @(negedge clk);
        rst = 1'b0;
        do_instr(11'h458, {3'b000, 4'b0010, 3'b000}, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            do_instr(11'h0B3, {3'b000, 4'b0111, 3'b011}, 0, 0, 1'b0);
        check("retired_wrap_17", 32'(bus.retired), 32'h1);

        // Randomized instruction stream against the reference model.
        pool = '{11'h7C2, 11'h7C0, 11'h458, 11'h658, 11'h450, 11'h550,
                 11'h488, 11'h694, 11'h0A0, 11'h5A0};
        for (int i = 0; i < 200; i++) begin
            int fw, mw, r;
            r  = $urandom_range(0, 11);
            if (r < 10)       op = pool[r];
            else if (r == 10) op = junk();
            else              op = 11'h7FF;
            if (op == 11'h488 || op == 11'h694) op = op | 11'($urandom_range(0, 1));
            if (op == 11'h694) op = op | 11'($urandom_range(0, 3));
            if (op == 11'h0A0) op = op | 11'($urandom_range(0, 31));
            if (op == 11'h5A0) op = op | 11'($urandom_range(0, 7));
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            ref_model(op, cls, d);
            do_instr(op, d, fw, mw, rb());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
